// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mont_pkg
// Description : Shared types and width helpers for the Montgomery modular
//               exponentiation sequencer and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_pkg;

  // Default operand width W, product width 2W and exponent geometry
  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 2 * OPERAND_W;
  localparam int EXP_W     = 8;
  localparam int EXP_IDX_W = $clog2(EXP_W);

  // Sequencer states; conversion states are only visited in the
  // plain-form build
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONV_IN  = 3'd1,
    S_SQUARE   = 3'd2,
    S_MULT     = 3'd3,
    S_CONV_OUT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Bit index width for an exponent of e bits (at least one bit)
  function automatic int idx_width(input int e);
    return (e > 1) ? $clog2(e) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/montgomery_mul.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_mul
// Description : Combinational Montgomery product: W x W multiply feeding a
//               single montgomery_reduce instance. o_p = a*b*R^-1 mod m.
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_mul
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = OPERAND_W
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_modulus,
  input  logic [DATA_WIDTH-1:0] i_r_div_two,
  output logic [DATA_WIDTH-1:0] o_p
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [PROD_W-1:0] w_prod;

  assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};

  montgomery_reduce #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reduce (
    .i_t         (w_prod),
    .i_modulant  (i_modulus),
    .i_r_div_two (i_r_div_two),
    .o_result    (o_p)
  );

endmodule
`default_nettype wire

// File: rtl/montgomery_reduce.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_reduce
// Description : Combinational Montgomery reduction: o_result = t * R^-1 mod m,
//               R = 2^k with k taken from the single set bit of R/2.
//               Inputs below m*R give a fully reduced result below m.
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_reduce
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = OPERAND_W
) (
  input  logic [2*DATA_WIDTH-1:0] i_t,
  input  logic [DATA_WIDTH-1:0]   i_modulant,
  input  logic [DATA_WIDTH-1:0]   i_r_div_two,
  output logic [DATA_WIDTH-1:0]   o_result
);

  localparam int ACC_W = 2 * DATA_WIDTH + 1;

  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_mod_ext;

  assign w_mod_ext = {{(ACC_W - DATA_WIDTH){1'b0}}, i_modulant};

  // Bit-serial REDC unrolled over k steps: make the value even by adding m,
  // then halve; a single conditional subtract finishes the reduction
  always_comb begin
    w_acc = {1'b0, i_t};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if ((i_r_div_two >> i) != '0) begin
        if (w_acc[0]) begin
          w_acc = w_acc + w_mod_ext;
        end
        w_acc = w_acc >> 1;
      end
    end
    if (w_acc >= w_mod_ext) begin
      w_acc = w_acc - w_mod_ext;
    end
    o_result = w_acc[DATA_WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/montgomery_modexp.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_modexp
// Description : Left-to-right square-and-multiply sequencer computing
//               base^exp mod m on one Montgomery product per clock.
//               Build option MODEXP_CONVERT_EN: adds the r2_mod port and
//               converts base into / result out of Montgomery form.
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_modexp
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = OPERAND_W,
  parameter int EXP_WIDTH  = EXP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exp,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic [DATA_WIDTH-1:0] R_div_two,
  input  logic [DATA_WIDTH-1:0] one_mont,
`ifdef MODEXP_CONVERT_EN
  input  logic [DATA_WIDTH-1:0] r2_mod,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int IDX_W = idx_width(EXP_WIDTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_base;
  logic [EXP_WIDTH-1:0]  r_exp;
  logic [DATA_WIDTH-1:0] r_mod;
  logic [DATA_WIDTH-1:0] r_rdt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_result;
`ifdef MODEXP_CONVERT_EN
  logic [DATA_WIDTH-1:0] r_r2;
`endif

  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_prod;
  logic                  w_last;

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

  // Current cycle finishes bit 0 of the exponent
  assign w_last = (r_idx == '0) &&
                  ((r_state == S_MULT) ||
                   ((r_state == S_SQUARE) && !r_exp[r_idx]));

  // Select the operand pair for this cycle's Montgomery product
  always_comb begin
    w_op_a = r_acc;
    w_op_b = r_acc;
    case (r_state)
      S_MULT: w_op_b = r_base;
`ifdef MODEXP_CONVERT_EN
      S_CONV_IN: begin
        w_op_a = r_base;
        w_op_b = r_r2;
      end
      S_CONV_OUT: w_op_b = DATA_WIDTH'(1);
`endif
      default: ;
    endcase
  end

  montgomery_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .i_a         (w_op_a),
    .i_b         (w_op_b),
    .i_modulus   (r_mod),
    .i_r_div_two (r_rdt),
    .o_p         (w_prod)
  );

  // Sequencer: accept, exponent scan, optional conversions, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_rdt    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
`ifdef MODEXP_CONVERT_EN
      r_r2     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        // Cancel leaves result and err untouched
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_base <= base;
              r_exp  <= exp;
              r_mod  <= modulus;
              r_rdt  <= R_div_two;
              r_acc  <= one_mont;
              r_idx  <= IDX_W'(EXP_WIDTH - 1);
              r_err  <= 1'b0;
`ifdef MODEXP_CONVERT_EN
              r_r2   <= r2_mod;
`endif
              if (!modulus[0]) begin
                // REDC needs an odd modulus: report straight away
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_err    <= 1'b1;
                r_result <= '0;
              end else begin
                r_busy <= 1'b1;
`ifdef MODEXP_CONVERT_EN
                r_state <= S_CONV_IN;
`else
                r_state <= S_SQUARE;
`endif
              end
            end
          end
`ifdef MODEXP_CONVERT_EN
          S_CONV_IN: begin
            r_base  <= w_prod;
            r_state <= S_SQUARE;
          end
          S_CONV_OUT: begin
            r_acc    <= w_prod;
            r_result <= w_prod;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
`endif
          S_SQUARE, S_MULT: begin
            r_acc <= w_prod;
            if (w_last) begin
`ifdef MODEXP_CONVERT_EN
              r_state <= S_CONV_OUT;
`else
              r_result <= w_prod;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
`endif
            end else if ((r_state == S_SQUARE) && r_exp[r_idx]) begin
              r_state <= S_MULT;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_SQUARE;
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_modexp.sv
`default_nettype none
// ============================================================================
// Module      : tb_montgomery_modexp
// Description : Self-checking bench for montgomery_modexp (W=8, E=4) against
//               a modular-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_modexp;

  localparam int W = 8;
  localparam int E = 4;
`ifdef MODEXP_CONVERT_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif
  localparam int EXTRA = CONV ? 2 : 0;
  // Scenario-1 base and its expected result in this build's number form
  localparam int BASE1 = CONV ? 2 : 5;
  localparam int RES1  = CONV ? 6 : 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] base = '0;
  logic [E-1:0] exp = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] R_div_two = '0;
  logic [W-1:0] one_mont = '0;
  logic [W-1:0] r2_mod = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  montgomery_modexp #(
    .DATA_WIDTH (W),
    .EXP_WIDTH  (E)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base      (base),
    .exp       (exp),
    .modulus   (modulus),
    .R_div_two (R_div_two),
    .one_mont  (one_mont),
`ifdef MODEXP_CONVERT_EN
    .r2_mod    (r2_mod),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  // ---------------- reference model ----------------
  function automatic int powmod(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int j = 0; j < e; j++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int rinv(input int r, input int m);
    for (int j = 1; j < m; j++) if (((r % m) * j) % m == 1) return j;
    return 0;
  endfunction

  // Expected result: plain base^exp mod m, mapped in/out of Montgomery form
  function automatic int model(input int b, input int e, input int m, input int k);
    int r, x, y;
    r = 1 << k;
    if (CONV != 0) return powmod(b % m, e, m);
    x = (b * rinv(r, m)) % m;
    y = powmod(x, e, m);
    return (y * (r % m)) % m;
  endfunction

  function automatic int exp_cycles(input int e);
    return E + $countones(e[E-1:0]) + 1 + EXTRA;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_ops(input int b, input int e, input int m, input int k);
    base      = W'(b);
    exp       = E'(e);
    modulus   = W'(m);
    R_div_two = W'(1 << (k - 1));
    one_mont  = W'((1 << k) % m);
    r2_mod    = W'(((1 << k) * (1 << k)) % m);
  endtask

  // Start one operation and wait (bounded) for done; leaves FSM back in IDLE
  task automatic run_op(input int b, input int e, input int m, input int k,
                        output int cyc, output int res, output logic er,
                        output logic b1, output logic bz);
    int c;
    @(negedge clk);
    drive_ops(b, e, m, k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; res = -1; er = 1'bx; bz = 1'bx;
    b1 = busy;
    c = 1;
    while (cyc == 0 && c <= 60) begin
      if (done) begin
        cyc = c; res = int'(result); er = err; bz = busy;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %0d expected 0", result); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_scenario1();
    int cyc, res; logic er, b1, bz;
    run_op(BASE1, 4'b0101, 13, 8, cyc, res, er, b1, bz);
    checks++; if (cyc !== 7 + EXTRA) begin failures++; $display("FAIL s1_latency: got %0d expected %0d", cyc, 7 + EXTRA); end
    checks++; if (res !== RES1 || res !== model(BASE1, 5, 13, 8)) begin failures++; $display("FAIL s1_result: got %0d expected %0d", res, RES1); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL s1_err: got %b expected 0", er); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL s1_busy_c1: got %b expected 1", b1); end
    checks++; if (bz !== 1'b0) begin failures++; $display("FAIL s1_busy_done: got %b expected 0", bz); end
  endtask

  task automatic test_exp_zero();
    int cyc, res; logic er, b1, bz;
    run_op(BASE1, 0, 13, 8, cyc, res, er, b1, bz);
    checks++; if (cyc !== 5 + EXTRA) begin failures++; $display("FAIL exp0_latency: got %0d expected %0d", cyc, 5 + EXTRA); end
    checks++; if (res !== (CONV ? 1 : 9)) begin failures++; $display("FAIL exp0_result: got %0d expected %0d", res, CONV ? 1 : 9); end
  endtask

  task automatic test_even_modulus();
    int cyc, res; logic er, b1, bz;
    run_op(BASE1, 4'b0101, 12, 8, cyc, res, er, b1, bz);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL even_latency: got %0d expected 1", cyc); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL even_err: got %b expected 1", er); end
    checks++; if (res !== 0) begin failures++; $display("FAIL even_result: got %0d expected 0", res); end
    run_op(BASE1, 4'b0101, 13, 8, cyc, res, er, b1, bz);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL even_err_clear: got %b expected 0", er); end
    checks++; if (res !== RES1) begin failures++; $display("FAIL even_next_result: got %0d expected %0d", res, RES1); end
  endtask

  task automatic test_ignore_start();
    int cyc, res, c;
    @(negedge clk);
    drive_ops(BASE1, 4'b0101, 13, 8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; res = -1; c = 1;
    while (cyc == 0 && c <= 60) begin
      if (c == 3) begin
        drive_ops(7, 4'b1111, 11, 8);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        cyc = c; res = int'(result);
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    checks++; if (cyc !== 7 + EXTRA) begin failures++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, 7 + EXTRA); end
    checks++; if (res !== RES1) begin failures++; $display("FAIL ignore_result: got %0d expected %0d", res, RES1); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [W-1:0] prev;
    int seen;
    prev = result;
    @(negedge clk);
    drive_ops(BASE1, 4'b0101, 13, 8);
    start = 1'b1;
    @(posedge clk); #1;              // cycle 1
    start = 1'b0;
    @(posedge clk); #1;              // cycle 2
    @(posedge clk); #1;              // cycle 3
    abort = 1'b1;
    @(posedge clk); #1;              // cycle 4
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    checks++; if (result !== prev) begin failures++; $display("FAIL abort_result_hold: got %0d expected %0d", result, prev); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err_hold: got %b expected 0", err); end
  endtask

  task automatic test_midrun_reset();
    int cyc, res; logic er, b1, bz;
    @(negedge clk);
    drive_ops(BASE1, 4'b0101, 13, 8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: got busy=%b done=%b err=%b expected 0/0/0", busy, done, err); end
    checks++; if (result !== '0) begin failures++; $display("FAIL midreset_result: got %0d expected 0", result); end
    @(negedge clk); reset = 1'b0;
    run_op(BASE1, 4'b0101, 13, 8, cyc, res, er, b1, bz);
    checks++; if (cyc !== 7 + EXTRA || res !== RES1) begin failures++; $display("FAIL midreset_rerun: got cyc=%0d res=%0d expected cyc=%0d res=%0d", cyc, res, 7 + EXTRA, RES1); end
  endtask

  task automatic test_random();
    int cyc, res, k, m, b, e, exp_res; logic er, b1, bz;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(4, 8));
      m = int'($urandom_range(1, (1 << (k - 1)) - 1)) * 2 + 1;
      b = int'($urandom_range(0, m - 1));
      e = int'($urandom_range(0, 15));
      exp_res = model(b, e, m, k);
      run_op(b, e, m, k, cyc, res, er, b1, bz);
      checks++;
      if (res !== exp_res || cyc !== exp_cycles(e) || er !== 1'b0) begin
        failures++;
        $display("FAIL random_%0d: b=%0d e=%0d m=%0d k=%0d got res=%0d cyc=%0d err=%b expected res=%0d cyc=%0d err=0",
                 n, b, e, m, k, res, cyc, er, exp_res, exp_cycles(e));
      end
    end
  endtask

  // start held high: a new run is accepted in the IDLE cycle after DONE
  task automatic test_back_to_back();
    int period, d1, d2, exp_res, e;
    e = 4'b1011;
    exp_res = model(BASE1, e, 13, 8);
    period = exp_cycles(e) + 1;
    @(negedge clk);
    drive_ops(BASE1, e, 13, 8);
    start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 2 * period + 4; c++) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
        checks++;
        if (result !== W'(exp_res)) begin failures++; $display("FAIL b2b_result_c%0d: got %0d expected %0d", c, result, exp_res); end
      end
      if (c == 2 * period) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (d1 !== period - 1) begin failures++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, period - 1); end
    checks++; if (d2 !== 2 * period - 1) begin failures++; $display("FAIL b2b_second_done: got %0d expected %0d", d2, 2 * period - 1); end
    repeat (period + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_scenario1();
    test_exp_zero();
    test_even_modulus();
    test_ignore_start();
    test_abort();
    test_midrun_reset();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
